decimator_avg: RTL and testbench

//  Boxcar-averaging decimator: accumulates Nfreq consecutive high-rate samples and emits their mean as one low-rate sample.

---
 rtl/decimator_avg_pkg.sv | 21 ++
 rtl/decimator_avg_seqdiv.sv | 72 +++++++
 rtl/decimator_avg.sv | 87 ++++++++
 tb/tb_decimator_avg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decimator_avg_pkg.sv
// Shared widths, divider state encoding and sign-extension helper for the
// boxcar-averaging decimator.
package decimator_avg_pkg;

    localparam int DW   = 18;
    localparam int NW   = 4;
    localparam int ACCW = DW + NW;
    localparam int ITW  = $clog2(ACCW);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_LOAD = 2'd1,
        DIV_ITER = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    function automatic logic [ACCW-1:0] sext(input logic [DW-1:0] d);
        return {{(ACCW-DW){d[DW-1]}}, d};
    endfunction

endpackage

// File: rtl/decimator_avg_seqdiv.sv
// Unsigned restoring divider: ACCW-bit dividend by NW-bit divisor, one
// quotient bit per cycle, start/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture dividend and divisor, clear remainder
// ITER  | ACCW shift/subtract steps
// DONE  | quotient valid for this one cycle
module decimator_avg_seqdiv
    import decimator_avg_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [ACCW-1:0] dividend,
    input  logic [NW-1:0]   divisor,
    output logic [ACCW-1:0] quotient,
    output logic            busy,
    output logic            done
);

    div_state_t       state;
    logic [NW-1:0]    den;
    logic [NW-1:0]    rem;
    logic [ITW-1:0]   iter;
    logic [NW:0]      trial;

    // The dividend register doubles as the quotient: bits shift out the top
    // into the remainder while quotient bits shift in at the bottom.
    assign trial = {rem, quotient[ACCW-1]};
    assign busy  = (state != DIV_IDLE);
    assign done  = (state == DIV_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= DIV_IDLE;
            quotient <= '0;
            den      <= '0;
            rem      <= '0;
            iter     <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) state <= DIV_LOAD;
                end
                DIV_LOAD: begin
                    quotient <= dividend;
                    den      <= divisor;
                    rem      <= '0;
                    iter     <= ITW'(ACCW - 1);
                    state    <= DIV_ITER;
                end
                DIV_ITER: begin
                    if (trial >= {1'b0, den}) begin
                        rem      <= NW'(trial - {1'b0, den});
                        quotient <= {quotient[ACCW-2:0], 1'b1};
                    end else begin
                        rem      <= trial[NW-1:0];
                        quotient <= {quotient[ACCW-2:0], 1'b0};
                    end
                    iter <= iter - ITW'(1);
                    if (iter == '0) state <= DIV_DONE;
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/decimator_avg.sv
// Boxcar-averaging decimator: sums Nfreq input samples and emits their mean,
// divided by a sequential divider running alongside the next frame's accumulation.
module decimator_avg
    import decimator_avg_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 endatain,
    input  logic [NW-1:0]        Nfreq,
    input  logic signed [DW-1:0] datain,
    output logic signed [DW-1:0] dataout,
    output logic                 dataoutvalid,
    output logic                 busy,
    output logic                 overrun
);

    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] sum;
    logic [ACCW-1:0] sample_sum;
    logic [ACCW-1:0] sum_mag;
    logic [ACCW-1:0] quotient;
    logic [ACCW-1:0] neg_q;
    logic [NW-1:0]   cnt;
    logic [NW-1:0]   nlat;
    logic [NW-1:0]   nlat_eff;
    logic [NW-1:0]   divisor;
    logic            frame_end;
    logic            div_start;
    logic            div_done;
    logic [DW-1:0]   result;
    logic            unused_hi;

    // The frame length is taken live from Nfreq only on a frame's first sample.
    assign nlat_eff   = (cnt == '0) ? ((Nfreq == '0) ? NW'(1) : Nfreq) : nlat;
    assign frame_end  = endatain && (cnt == (nlat_eff - NW'(1)));
    assign div_start  = frame_end && !busy;
    assign sample_sum = acc + sext(datain);
    assign sum_mag    = sum[ACCW-1] ? (-sum) : sum;
    assign neg_q      = -quotient;
    assign result     = sum[ACCW-1] ? neg_q[DW-1:0] : quotient[DW-1:0];
    assign unused_hi  = ^{neg_q[ACCW-1:DW], quotient[ACCW-1:DW]};

    decimator_avg_seqdiv seqdiv_u (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (sum_mag),
        .divisor  (divisor),
        .quotient (quotient),
        .busy     (busy),
        .done     (div_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            acc          <= '0;
            sum          <= '0;
            cnt          <= '0;
            nlat         <= '0;
            divisor      <= '0;
            dataout      <= '0;
            dataoutvalid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (endatain) begin
                if (cnt == '0) nlat <= nlat_eff;
                if (frame_end) begin
                    acc <= '0;
                    cnt <= '0;
                    // sum and divisor stay frozen while the divider reads them
                    if (busy) begin
                        overrun <= 1'b1;
                    end else begin
                        sum     <= sample_sum;
                        divisor <= nlat_eff;
                    end
                end else begin
                    acc <= sample_sum;
                    cnt <= cnt + NW'(1);
                end
            end
            dataoutvalid <= div_done;
            if (div_done) dataout <= result;
        end
    end

endmodule

// File: tb/tb_decimator_avg.sv
// Scoreboard bench for decimator_avg: a frame-level averaging model predicts
// each output value and its arrival cycle; a monitor pops and compares.
module tb_decimator_avg;
    import decimator_avg_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 endatain;
    logic [NW-1:0]        Nfreq;
    logic signed [DW-1:0] datain;
    logic signed [DW-1:0] dataout;
    logic                 dataoutvalid;
    logic                 busy;
    logic                 overrun;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   frame[$];
    int   n_lat      = 1;
    int   last_acc   = 0;
    bit   have_acc   = 0;
    bit   m_overrun  = 0;
    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;

    decimator_avg dut (
        .clock        (clock),
        .reset        (reset),
        .endatain     (endatain),
        .Nfreq        (Nfreq),
        .datain       (datain),
        .dataout      (dataout),
        .dataoutvalid (dataoutvalid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: mean of the frame's samples, truncated toward zero; the
    // divider is occupied for ACCW+2 edges after an accepted frame.
    task automatic model_sample(input int d, input int edge_idx);
        int s;
        if (frame.size() == 0) n_lat = (int'(Nfreq) == 0) ? 1 : int'(Nfreq);
        frame.push_back(d);
        if (frame.size() == n_lat) begin
            s = 0;
            foreach (frame[i]) s += frame[i];
            if (have_acc && (edge_idx - last_acc) < ACCW + 3) begin
                m_overrun = 1;
            end else begin
                exp_q.push_back('{s / n_lat, edge_idx + ACCW + 2});
                last_acc = edge_idx;
                have_acc = 1;
            end
            frame.delete();
        end
    endtask

    task automatic send(input int d, input int spacing);
        @(negedge clock);
        endatain = 1'b1;
        datain   = DW'(d);
        model_sample(d, cyc + 1);
        @(negedge clock);
        endatain = 1'b0;
        repeat (spacing - 2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        endatain = 1'b0;
        exp_q.delete();
        frame.delete();
        have_acc  = 0;
        m_overrun = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (ACCW + 4) @(negedge clock);
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_valid: no pulse by cycle %0d, expected value %0d", exp_q[0].due, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (dataoutvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: dataout=%0d at cycle %0d, none expected", dataout, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(dataout) != e.val || cyc != e.due) begin
                        errors++;
                        $display("FAIL output: dataout=%0d at cycle %0d, expected %0d at cycle %0d",
                                 dataout, cyc, e.val, e.due);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        endatain = 1'b0;
        Nfreq    = '0;
        datain   = '0;
        repeat (3) @(negedge clock);
        check("reset_dataout", int'(dataout), 0);
        check("reset_valid", int'(dataoutvalid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b0;

        Nfreq = 4'd4;
        for (int i = 0; i < 8; i++) send(1000, 8);
        drain("nf4_const");

        Nfreq = 4'd3;
        send(1, 9); send(2, 9); send(4, 9);
        send(-1, 9); send(-2, 9); send(-4, 9);
        drain("nf3_trunc");

        Nfreq = 4'd15;
        for (int i = 0; i < 15; i++) send(131071, 2);
        for (int i = 0; i < 15; i++) send(-131072, 2);
        drain("nf15_extremes");

        Nfreq = 4'd0;
        send(-5, 30); send(-5, 30);
        Nfreq = 4'd1;
        send(-5, 30); send(-5, 30);
        drain("nf0_nf1_pass");

        Nfreq = 4'd4;
        send(10, 8); send(20, 8);
        Nfreq = 4'd2;
        send(30, 8); send(41, 8);
        drain("nf_change_midframe");
        check("no_overrun_so_far", int'(overrun), 0);

        // Divider activity is visible one cycle after the frame's last sample.
        Nfreq = 4'd1;
        @(negedge clock);
        endatain = 1'b1;
        datain   = DW'(777);
        model_sample(777, cyc + 1);
        @(negedge clock);
        endatain = 1'b0;
        check("busy_after_frame", int'(busy), 1);
        drain("busy_frame");

        do_reset();
        Nfreq = 4'd1;
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 1000)) - 500, 10);
        drain("overrun_spacing10");
        check("overrun_set", int'(overrun), 1);
        check("overrun_model", int'(overrun), int'(m_overrun));
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 1000)) - 500, 64);
        drain("overrun_sticky_traffic");
        check("overrun_sticky", int'(overrun), 1);

        do_reset();
        Nfreq = 4'd1;
        for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 2000)) - 1000, 64);
        drain("spacing64");
        check("overrun_clear_64", int'(overrun), 0);

        // Abort the divider mid-iteration.
        Nfreq = 4'd2;
        send(300, 2);
        @(negedge clock);
        endatain = 1'b1;
        datain   = DW'(500);
        @(negedge clock);
        endatain = 1'b0;
        repeat (8) @(negedge clock);
        do_reset();
        check("abort_dataout", int'(dataout), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(dataoutvalid), 0);
        repeat (ACCW + 4) @(negedge clock);
        Nfreq = 4'd2;
        send(-7, 20); send(2, 20);
        drain("after_abort");

        do_reset();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) Nfreq = NW'($urandom_range(0, 15));
            send(int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(2, 7)));
        end
        drain("random");
        check("random_overrun", int'(overrun), int'(m_overrun));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
